// File: rtl/amp_bcd_to_bin_pkg.sv
// Shared types and constants for the amplitude BCD-to-binary converter.
package amp_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    localparam int unsigned AMP_W    = 12;
    localparam int unsigned AMP_ITER = AMP_W + 1;
    localparam logic [AMP_W-1:0] AMP_MAX = 12'hFFF;
    localparam int unsigned BCD_W    = 15;

endpackage

// File: rtl/amp_bcd_to_bin_if.sv
// Digit/result handshake bundle between the amplitude entry logic and the converter.
interface amp_bcd_to_bin_if #(
    parameter int unsigned OUT_W = 12
);
    logic             start;
    logic [2:0]       thousand;
    logic [3:0]       hundred;
    logic [3:0]       ten;
    logic [3:0]       one;
    logic [OUT_W-1:0] data_out;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, thousand, hundred, ten, one,
        input  data_out, busy, done, err
    );

    modport slave (
        input  start, thousand, hundred, ten, one,
        output data_out, busy, done, err
    );
endinterface

// File: rtl/amp_bcd_to_bin_nibble_adj.sv
// Reverse double-dabble digit correction: a nibble of 8 or more has 3 subtracted.
module bcd_nibble_adj (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);
    assign nib_o = (nib_i >= 4'd8) ? (nib_i - 4'd3) : nib_i;
endmodule

// File: rtl/amp_bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one shift per clock).
// Build macro AMP_BCD_SAT_EN: saturate overflow to all-ones instead of flagging err.
module amp_bcd_to_bin
    import amp_bcd_pkg::*;
#(
    parameter int unsigned OUT_W = AMP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    amp_bcd_to_bin_if.slave  bus
);
    localparam int unsigned ITER  = OUT_W + 1;
    localparam int unsigned CNT_W = $clog2(ITER);

    state_t             state_q, state_d;
    // Thousands digit is held zero-extended so all four nibbles share one correction path.
    logic [BCD_W:0]     bcd_q, bcd_d;
    logic [OUT_W:0]     bin_q, bin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bad_q, bad_d;
    logic [OUT_W-1:0]   data_q, data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [BCD_W:0]     bcd_sh;
    logic [BCD_W:0]     bcd_adj;

    assign bcd_sh = bcd_q >> 1;

    for (genvar g = 0; g < 4; g++) begin : g_adj
        bcd_nibble_adj u_adj (
            .nib_i (bcd_sh[g*4 +: 4]),
            .nib_o (bcd_adj[g*4 +: 4])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            bad_q   <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            bad_q   <= bad_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        bad_d   = bad_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    bcd_d   = {1'b0, bus.thousand, bus.hundred, bus.ten, bus.one};
                    bin_d   = '0;
                    cnt_d   = '0;
                    bad_d   = (bus.hundred > 4'd9) || (bus.ten > 4'd9) || (bus.one > 4'd9);
                    busy_d  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d = bcd_adj;
                bin_d = {bcd_q[0], bin_q[OUT_W:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (bad_q) begin
                    err_d = 1'b1;
                end else if (!bin_q[OUT_W]) begin
                    data_d = bin_q[OUT_W-1:0];
                    err_d  = 1'b0;
                end else begin
`ifdef AMP_BCD_SAT_EN
                    data_d = '1;
                    err_d  = 1'b0;
`else
                    err_d  = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.data_out = data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_amp_bcd_to_bin.sv
// Scoreboard bench for amp_bcd_to_bin: directed digit vectors, monitor checks each done pulse.
module tb_amp_bcd_to_bin;
    import amp_bcd_pkg::*;

    typedef struct {
        logic [11:0] data;
        logic        err;
        int unsigned cyc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int unsigned cyc = 0;
    int unsigned busy_cnt = 0;
    int n_tests = 0;
    int n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    amp_bcd_to_bin_if #(.OUT_W(AMP_W)) bus ();

    amp_bcd_to_bin #(.OUT_W(AMP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_data"}, 32'(bus.data_out), 32'(e.data));
                    chk({e.name, "_err"}, 32'(bus.err), 32'(e.err));
                    chk({e.name, "_latency"}, cyc, e.cyc);
                    chk({e.name, "_busy_cycles"}, busy_cnt, 32'd13);
                    chk({e.name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
                end
                busy_cnt = 0;
            end
        end
    end

    // Drives start for one edge; caller sits at a negedge beforehand.
    task automatic send(input logic [2:0] th, input logic [3:0] hu, input logic [3:0] te,
                        input logic [3:0] on, input logic [11:0] ed, input logic ee,
                        input string nm, input bit push);
        bus.thousand = th;
        bus.hundred  = hu;
        bus.ten      = te;
        bus.one      = on;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        if (push) sb.push_back('{data: ed, err: ee, cyc: cyc + 14, name: nm});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        if (!seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run(input logic [2:0] th, input logic [3:0] hu, input logic [3:0] te,
                       input logic [3:0] on, input logic [11:0] ed, input logic ee,
                       input string nm);
        repeat (2) @(negedge clk);
        send(th, hu, te, on, ed, ee, nm, 1'b1);
        wait_done(nm);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.thousand = '0;
        bus.hundred  = '0;
        bus.ten      = '0;
        bus.one      = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_data", 32'(bus.data_out), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err",  32'(bus.err),  32'd0);
        rst_n = 1'b1;

        run(3'd1, 4'd2, 4'd3, 4'd4, 12'h4D2, 1'b0, "v1234");
`ifdef AMP_BCD_SAT_EN
        run(3'd4, 4'd0, 4'd9, 4'd6, 12'hFFF, 1'b0, "v4096_sat");
`else
        run(3'd4, 4'd0, 4'd9, 4'd6, 12'h4D2, 1'b1, "v4096_ovf");
`endif
        run(3'd0, 4'd0, 4'd0, 4'd0, 12'h000, 1'b0, "v0000");
`ifdef AMP_BCD_SAT_EN
        run(3'd5, 4'd0, 4'd0, 4'd0, 12'hFFF, 1'b0, "v5000_sat");
`else
        run(3'd5, 4'd0, 4'd0, 4'd0, 12'h000, 1'b1, "v5000_ovf");
`endif
        run(3'd4, 4'd0, 4'd9, 4'd5, 12'hFFF, 1'b0, "v4095");
        run(3'd1, 4'd2, 4'hA, 4'd4, 12'hFFF, 1'b1, "bad_ten");
        run(3'd5, 4'd0, 4'hA, 4'd0, 12'hFFF, 1'b1, "bad_ten_ovf");
        run(3'd0, 4'd9, 4'd9, 4'd9, 12'h3E7, 1'b0, "v0999");
        // Issued in the done cycle of the previous conversion.
        send(3'd2, 4'd5, 4'd0, 4'd0, 12'h9C4, 1'b0, "b2b_2500", 1'b1);
        wait_done("b2b_2500");
        send(3'd0, 4'hF, 4'd0, 4'd0, 12'h9C4, 1'b1, "b2b_bad_hun", 1'b1);
        wait_done("b2b_bad_hun");

        // start during CONV with new digits must be ignored.
        repeat (2) @(negedge clk);
        send(3'd0, 4'd0, 4'd4, 4'd2, 12'h02A, 1'b0, "v0042", 1'b1);
        repeat (4) @(negedge clk);
        bus.thousand = 3'd3;
        bus.hundred  = 4'd3;
        bus.ten      = 4'd3;
        bus.one      = 4'd3;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("v0042");

        // Reset mid-conversion: outputs clear at once and no done appears.
        repeat (2) @(negedge clk);
        send(3'd1, 4'd1, 4'd1, 4'd1, 12'h000, 1'b0, "aborted", 1'b0);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_data", 32'(bus.data_out), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_err",  32'(bus.err),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        run(3'd0, 4'd0, 4'd7, 4'd7, 12'h04D, 1'b0, "post_rst_0077");

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
